// File: rtl/dac16_rx.sv
// dac16_rx: oversampling receiver for 24-bit SYNC/SCLK/DIN DAC frames (MSB first).
// Optional build macro DAC16_RX_CTRL_CHECK_EN rejects frames with a nonzero control field.
`timescale 1ns/1ps
module dac16_rx #(
    parameter int FRAME_BITS = 24,
    parameter int DATA_BITS  = 16
) (
    input  logic                             CLK_50,
    input  logic                             RESET_N,
    input  logic                             SYNC,
    input  logic                             SCLK,
    input  logic                             DIN,
    output logic [DATA_BITS-1:0]             DATA16,
    output logic [FRAME_BITS-DATA_BITS-1:0]  CTRL8,
    output logic                             VALID,
    output logic                             FRAME_ERR,
    output logic                             BUSY,
    output logic [7:0]                       FRAME_CNT
);
    localparam int              CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic [2:0]              sync_q_r, sclk_q_r;
    logic [1:0]              din_q_r;
    logic [1:0]              settle_r;
    logic                    armed_r;
    logic [FRAME_BITS-1:0]   shreg_r;
    logic [CNT_W-1:0]        bitcnt_r;
    logic                    sync_rise_s, sync_fall_s, sclk_rise_s;
    logic [CNT_W-1:0]        cnt_inc_s, cnt_upd_s;
    logic                    ctrl_bad_s;
    logic                    busy_s, valid_s, err_s;

    // Input synchronisers plus edge-detect stage; idle levels are SYNC=1, SCLK=0, DIN=0
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q_r <= 3'b111;
            sclk_q_r <= 3'b000;
            din_q_r  <= 2'b00;
        end else begin
            sync_q_r <= {sync_q_r[1:0], SYNC};
            sclk_q_r <= {sclk_q_r[1:0], SCLK};
            din_q_r  <= {din_q_r[0], DIN};
        end
    end

    // A SYNC fall only counts once the synchronised line has been seen high after reset,
    // so a frame already in progress at reset release is dropped
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            settle_r <= 2'd0;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= (settle_r == 2'd3) ? settle_r : settle_r + 2'd1;
            armed_r  <= armed_r | ((settle_r == 2'd3) & sync_q_r[1] & sync_q_r[2]);
        end
    end

    assign sync_rise_s = sync_q_r[1] & ~sync_q_r[2];
    assign sync_fall_s = ~sync_q_r[1] & sync_q_r[2] & armed_r;
    assign sclk_rise_s = sclk_q_r[1] & ~sclk_q_r[2];
    assign cnt_inc_s   = (bitcnt_r == CNT_SAT) ? bitcnt_r : bitcnt_r + 5'd1;
    // Close is judged on the count including a bit clocked in the same cycle
    assign cnt_upd_s   = sclk_rise_s ? cnt_inc_s : bitcnt_r;

`ifdef DAC16_RX_CTRL_CHECK_EN
    assign ctrl_bad_s = |shreg_r[FRAME_BITS-1:DATA_BITS];
`else
    assign ctrl_bad_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sync_fall_s) state_next_s = ST_SHIFT;
                else             state_next_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (sync_rise_s) state_next_s = (cnt_upd_s == CNT_FULL) ? ST_DONE : ST_IDLE;
                else             state_next_s = ST_SHIFT;
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, registered below
    always_comb begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = (state_next_s == ST_SHIFT);
            end
            ST_SHIFT: begin
                busy_s = (state_next_s != ST_IDLE);
                err_s  = sync_rise_s & (cnt_upd_s != CNT_FULL);
            end
            ST_DONE: begin
                valid_s = ~ctrl_bad_s;
                err_s   = ctrl_bad_s;
            end
            default: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
                err_s   = 1'b0;
            end
        endcase
    end

    // Deserialiser: shift register and saturating bit counter
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg_r  <= '0;
            bitcnt_r <= 5'd0;
        end else if (state_r == ST_IDLE && sync_fall_s) begin
            shreg_r  <= '0;
            bitcnt_r <= 5'd0;
        end else if (state_r == ST_SHIFT && sclk_rise_s) begin
            shreg_r  <= {shreg_r[FRAME_BITS-2:0], din_q_r[1]};
            bitcnt_r <= cnt_inc_s;
        end else begin
            shreg_r  <= shreg_r;
            bitcnt_r <= bitcnt_r;
        end
    end

    // Output registers; frame fields and count only change on a good frame
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            BUSY      <= 1'b0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            DATA16    <= '0;
            CTRL8     <= '0;
            FRAME_CNT <= 8'd0;
        end else begin
            BUSY      <= busy_s;
            VALID     <= valid_s;
            FRAME_ERR <= err_s;
            if (valid_s) begin
                DATA16    <= shreg_r[DATA_BITS-1:0];
                CTRL8     <= shreg_r[FRAME_BITS-1:DATA_BITS];
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end else begin
                DATA16    <= DATA16;
                CTRL8     <= CTRL8;
                FRAME_CNT <= FRAME_CNT;
            end
        end
    end
endmodule

// File: tb/tb_dac16_rx.sv
// Self-checking bench for dac16_rx: frame table, random frames against a frame-level model,
// and hand sequences for latency, reset, back-to-back and counter wrap.
`timescale 1ns/1ps
module tb_dac16_rx;
`ifdef DAC16_RX_CTRL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        CLK_50, RESET_N, SYNC, SCLK, DIN;
    logic [15:0] DATA16;
    logic [7:0]  CTRL8, FRAME_CNT;
    logic        VALID, FRAME_ERR, BUSY;

    dac16_rx dut (
        .CLK_50(CLK_50), .RESET_N(RESET_N), .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN),
        .DATA16(DATA16), .CTRL8(CTRL8), .VALID(VALID), .FRAME_ERR(FRAME_ERR),
        .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );

    initial CLK_50 = 1'b0;
    always #10 CLK_50 = ~CLK_50;

    typedef struct {
        bit          good;
        logic [7:0]  ctrl;
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          phase;
        int          gap;
        bit          same_edge;
        bit          exp_good;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  m_cnt  = 8'd0;
    logic [7:0]  m_ctrl = 8'd0;
    logic [15:0] m_data = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_50);
    endtask

    // Frame-level model: a frame is good iff exactly 24 bits and (when checking) control is zero
    function automatic bit model_good(input logic [31:0] word, input int nbits);
        logic [7:0] c;
        c = word[23:16];
        return (nbits == 24) && !(CHK && (c != 8'd0));
    endfunction

    task automatic push_exp(input bit good, input logic [31:0] word);
        exp_t e;
        if (good) begin
            m_cnt  = m_cnt + 8'd1;
            m_ctrl = word[23:16];
            m_data = word[15:0];
        end
        e.good = good; e.ctrl = m_ctrl; e.data = m_data; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_cnt = 8'd0; m_ctrl = 8'd0; m_data = 16'd0;
        exp_q.delete();
    endtask

    task automatic send_bits(input logic [31:0] word, input int n, input int phase);
        for (int i = 0; i < n; i++) begin
            DIN = word[n-1-i];
            tick(phase);
            SCLK = 1'b1;
            tick(phase);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [31:0] word, input int nbits, input int phase,
                             input int gap, input bit same_edge, input bit good);
        SYNC = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            DIN = word[nbits-1-i];
            tick(phase);
            SCLK = 1'b1;
            if (same_edge && i == nbits - 1) begin
                SYNC = 1'b1;
                push_exp(good, word);
            end
            tick(phase);
            SCLK = 1'b0;
        end
        if (!(same_edge && nbits > 0)) begin
            tick(phase);
            SYNC = 1'b1;
            push_exp(good, word);
        end
        tick(gap);
    endtask

    task automatic check_idle(input string tag);
        tick(8);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_data16"}, DATA16, m_data);
        chk({tag, "_ctrl8"}, CTRL8, m_ctrl);
        chk({tag, "_frame_cnt"}, FRAME_CNT, m_cnt);
        chk({tag, "_busy"}, BUSY, 1'b0);
    endtask

    // First-occurrence cycle numbers (1-based negedges) of BUSY high/low, VALID, FRAME_ERR
    task automatic wait_lat(output int kbh, output int kbl, output int kv, output int ke);
        kbh = 0; kbl = 0; kv = 0; ke = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK_50);
            if (kbh == 0 && BUSY)      kbh = i;
            if (kbl == 0 && !BUSY)     kbl = i;
            if (kv == 0 && VALID)      kv = i;
            if (ke == 0 && FRAME_ERR)  ke = i;
        end
    endtask

    // Monitor: every VALID/FRAME_ERR pulse must match the next expected frame outcome
    always @(negedge CLK_50) begin
        if (RESET_N && (VALID || FRAME_ERR)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected none", VALID, FRAME_ERR);
            end else begin
                mon_e = exp_q.pop_front();
                if (VALID !== mon_e.good || FRAME_ERR !== !mon_e.good ||
                    (mon_e.good && ({CTRL8, DATA16, FRAME_CNT} !== {mon_e.ctrl, mon_e.data, mon_e.cnt}))) begin
                    n_fail++;
                    $display("FAIL frame_result: got valid=%0b err=%0b ctrl=%h data=%h cnt=%0d, expected good=%0b ctrl=%h data=%h cnt=%0d",
                             VALID, FRAME_ERR, CTRL8, DATA16, FRAME_CNT,
                             mon_e.good, mon_e.ctrl, mon_e.data, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int   kbh, kbl, kv, ke, busy_hi, nb;
        logic [31:0] w;

        tbl[0] = '{32'h0000_A5C3, 24, 10, 5, 1'b0, 1'b1};
        tbl[1] = '{32'h0012_3456, 23,  4, 5, 1'b0, 1'b0};
        tbl[2] = '{32'h00AB_CDEF, 25,  4, 5, 1'b0, 1'b0};
        tbl[3] = '{32'h005A_1234, 24,  5, 5, 1'b0, !CHK};
        tbl[4] = '{32'h0000_BEEF, 24,  3, 3, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0000, 24,  4, 4, 1'b0, 1'b1};
        tbl[6] = '{32'h00FF_0001, 24,  3, 4, 1'b1, !CHK};
        tbl[7] = '{32'h0000_F00D,  0,  4, 4, 1'b0, 1'b0};

        SYNC = 1'b1; SCLK = 1'b0; DIN = 1'b0; RESET_N = 1'b1;
        #5 RESET_N = 1'b0;
        #1;
        chk("rst_data16", DATA16, 16'h0);
        chk("rst_ctrl8", CTRL8, 8'h0);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_frame_err", FRAME_ERR, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_frame_cnt", FRAME_CNT, 8'h0);
        tick(3);
        RESET_N = 1'b1;
        tick(6);

        // First frame with latency measurement
        SYNC = 1'b0;
        wait_lat(kbh, kbl, kv, ke);
        chk("busy_rise_lat", kbh, 3);
        send_bits(32'h0000_A5C3, 24, 10);
        SYNC = 1'b1;
        push_exp(1'b1, 32'h0000_A5C3);
        wait_lat(kbh, kbl, kv, ke);
        chk("valid_lat", kv, 4);
        chk("busy_fall_lat", kbl, 4);
        chk("first_data16", DATA16, 16'hA5C3);
        chk("first_frame_cnt", FRAME_CNT, 8'd1);

        // Short frame error latency
        SYNC = 1'b0;
        tick(5);
        send_bits(32'h0000_7777, 23, 4);
        SYNC = 1'b1;
        push_exp(1'b0, 32'h0);
        wait_lat(kbh, kbl, kv, ke);
        chk("err_lat", ke, 3);
        chk("busy_fall_err_lat", kbl, 3);
        check_idle("lat");

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].word, tbl[i].nbits, tbl[i].phase, tbl[i].gap,
                      tbl[i].same_edge, tbl[i].exp_good);
            check_idle($sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[23:16] = 8'd0;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(22, 26)) : 24;
            run_frame(w, nb, int'($urandom_range(3, 5)), int'($urandom_range(3, 6)),
                      1'($urandom_range(0, 1)), model_good(w, nb));
        end
        check_idle("rand");

        // Free-running SCLK with SYNC high
        busy_hi = 0;
        for (int i = 0; i < 120; i++) begin
            SCLK = 1'((i / 3) % 2);
            DIN  = 1'($urandom_range(0, 1));
            @(negedge CLK_50);
            if (BUSY) busy_hi++;
        end
        SCLK = 1'b0;
        chk("free_sclk_busy", busy_hi, 0);
        check_idle("free_sclk");

        // Reset in the middle of a frame; SYNC stays low across the release
        SYNC = 1'b0;
        tick(4);
        send_bits(32'h00C3_3C3C, 12, 4);
        RESET_N = 1'b0;
        #1;
        chk("midrst_data16", DATA16, 16'h0);
        chk("midrst_ctrl8", CTRL8, 8'h0);
        chk("midrst_frame_cnt", FRAME_CNT, 8'h0);
        chk("midrst_busy", BUSY, 1'b0);
        model_reset();
        tick(3);
        RESET_N = 1'b1;
        tick(2);
        send_bits(32'h0000_0FFF, 12, 4);
        tick(4);
        SYNC = 1'b1;
        tick(6);
        check_idle("partial");
        run_frame(32'h0000_0F0F, 24, 4, 4, 1'b0, 1'b1);
        check_idle("after_rst");
        chk("after_rst_data16", DATA16, 16'h0F0F);

        // Back-to-back frames at minimum spacing after a fresh reset
        RESET_N = 1'b0;
        model_reset();
        tick(2);
        RESET_N = 1'b1;
        tick(5);
        for (int i = 0; i < 10; i++)
            run_frame(32'(i), 24, 3, 3, 1'b0, 1'b1);
        check_idle("b2b");
        chk("b2b_cnt_10", FRAME_CNT, 8'd10);

        for (int i = 0; i < 246; i++) begin
            w = $urandom & 32'h0000_FFFF;
            run_frame(w, 24, 3, 3, 1'b0, 1'b1);
        end
        check_idle("wrap");
        chk("wrap_cnt_0", FRAME_CNT, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
